// File: rtl/pixel_stream_proc.sv
// Streaming pixel processor: bypass, invert, threshold or 3x3 convolution per frame,
// with a single registered output stage and a small byte-wide register file.
module pixel_stream_proc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_pixel,
  input  logic                  reg_write_en,
  input  logic [4:0]            reg_addr,
  input  logic [7:0]            reg_wdata,
  output logic [7:0]            reg_rdata
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned CMP_W = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_CONV   = 2'b10,
    MODE_THRESH = 2'b11
  } mode_e;

  mode_e                  mode_q, active_mode_q, cur_mode;
  logic [7:0]             threshold_q, frame_count_q;
  logic signed [7:0]      kernel_q [9];
  logic                   err_sticky_q, primed_q;
  logic [COL_W-1:0]       col_q, cur_col, next_col;
  logic [1:0]             row_q, cur_row, next_row;
  logic [DATA_WIDTH-1:0]  lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]  lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]  win_q [3][3];
  logic [DATA_WIDTH-1:0]  new_col [3];
  logic [DATA_WIDTH-1:0]  inv_data, px_max;
  logic signed [OUT_WIDTH-1:0] conv_acc;
  logic [OUT_WIDTH-1:0]   result;
  logic                   produce, accept, last_col;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is processed in the newly loaded mode at position (0,0).
  assign cur_mode = in_sof ? mode_q : active_mode_q;
  assign cur_col  = in_sof ? '0 : col_q;
  assign cur_row  = in_sof ? 2'd0 : row_q;
  assign last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
  assign next_col = last_col ? '0 : cur_col + 1'b1;
  assign next_row = (last_col && cur_row != 2'd2) ? cur_row + 2'd1 : cur_row;

  assign new_col[0] = lb2[cur_col];
  assign new_col[1] = lb1[cur_col];
  assign new_col[2] = in_data;
  assign inv_data   = ~in_data;
  assign px_max     = '1;

  // Window taps for the current pixel: two stored columns plus the incoming column.
  always_comb begin
    conv_acc = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [DATA_WIDTH-1:0] tap;
        tap = (c == 2) ? new_col[r] : win_q[r][c+1];
        conv_acc = conv_acc + $signed(OUT_WIDTH'(tap)) * OUT_WIDTH'(kernel_q[r*3+c]);
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    result  = '0;
    produce = 1'b1;
    case (cur_mode)
      MODE_BYPASS: result = OUT_WIDTH'(in_data);
      MODE_INVERT: result = OUT_WIDTH'(inv_data);
      MODE_THRESH: result = (CMP_W'(in_data) >= CMP_W'(threshold_q)) ? OUT_WIDTH'(px_max) : '0;
      MODE_CONV: begin
        result  = conv_acc;
        produce = (cur_row == 2'd2) && (cur_col >= COL_W'(2));
      end
      default: result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid     <= 1'b0;
      out_pixel     <= '0;
      active_mode_q <= MODE_BYPASS;
      col_q         <= '0;
      row_q         <= 2'd0;
      primed_q      <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      if (accept && produce) begin
        out_valid <= 1'b1;
        out_pixel <= result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        col_q    <= next_col;
        row_q    <= next_row;
        primed_q <= (next_row == 2'd2);
        if (in_sof) begin
          active_mode_q <= mode_q;
          frame_count_q <= frame_count_q + 8'd1;
        end
      end
    end
  end

  // NOTE: line buffers and window are data-only storage; stale contents are never used
  // before row 2 of a frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= in_data;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q       <= MODE_BYPASS;
      threshold_q  <= 8'h80;
      err_sticky_q <= 1'b0;
      for (int i = 0; i < 9; i++) kernel_q[i] <= (i == 4) ? 8'sd1 : 8'sd0;
    end else begin
      if (in_valid && !in_ready && in_sof) begin
        err_sticky_q <= 1'b1;
      end else if (reg_write_en && reg_addr == 5'h10) begin
        err_sticky_q <= 1'b0;
      end
      if (reg_write_en) begin
        if (reg_addr == 5'h00) mode_q <= mode_e'(reg_wdata[1:0]);
        if (reg_addr == 5'h01) threshold_q <= reg_wdata;
        for (int i = 0; i < 9; i++) begin
          if (reg_addr == 5'(4 + i)) kernel_q[i] <= $signed(reg_wdata);
        end
      end
    end
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      5'h00:   reg_rdata = {6'd0, mode_q};
      5'h01:   reg_rdata = threshold_q;
      5'h10:   reg_rdata = {4'hA, err_sticky_q, primed_q, active_mode_q};
      5'h11:   reg_rdata = frame_count_q;
      default: begin
        for (int i = 0; i < 9; i++) begin
          if (reg_addr == 5'(4 + i)) reg_rdata = kernel_q[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Directed bench for pixel_stream_proc with hand-computed expected values (IMG_WIDTH=4).
module tb_pixel_stream_proc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [7:0]  in_data = '0;
  logic [31:0] out_pixel;
  logic        reg_write_en = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [7:0]  reg_wdata = '0, reg_rdata;

  int errors = 0;
  int checks = 0;

  pixel_stream_proc #(.DATA_WIDTH(8), .IMG_WIDTH(4), .OUT_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .reg_write_en(reg_write_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
    reg_write_en = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_write_en = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    check(tag, 32'(reg_rdata), 32'(exp));
  endtask

  // Presents one pixel and returns just after the edge on which it was accepted.
  task automatic send(input logic [7:0] d, input logic sof);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic set_kernel(input logic [7:0] k [9]);
    for (int i = 0; i < 9; i++) reg_wr(5'(4 + i), k[i]);
  endtask

  // kind 0: constant 10; kind 1: 4*row+col+1; kind 2: 200 at (1,1), zero elsewhere.
  task automatic frame(input int kind, output int n_out, output int first_idx,
                       output logic [31:0] vals [4]);
    logic [7:0] p;
    n_out = 0; first_idx = -1;
    for (int i = 0; i < 4; i++) vals[i] = '0;
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       p = 8'd10;
        1:       p = 8'(i + 1);
        default: p = (i == 5) ? 8'd200 : 8'd0;
      endcase
      send(p, i == 0);
      if (out_valid) begin
        if (first_idx < 0) first_idx = i;
        if (n_out < 4) vals[n_out] = out_pixel;
        n_out++;
      end
    end
  endtask

  initial begin
    int n_out, first_idx;
    logic [31:0] vals [4];
    logic [7:0]  k [9];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", out_pixel, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reg_chk("rst_mode", 5'h00, 8'h00);
    reg_chk("rst_threshold", 5'h01, 8'h80);
    reg_chk("rst_k0", 5'h04, 8'h00);
    reg_chk("rst_k4", 5'h08, 8'h01);
    reg_chk("rst_status", 5'h10, 8'hA0);
    reg_chk("rst_frame_count", 5'h11, 8'h00);
    reg_chk("unmapped", 5'h1F, 8'h00);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Bypass
    send(8'h12, 1'b1);
    check("byp_valid0", 32'(out_valid), 32'd1);
    check("byp_pix0", out_pixel, 32'h12);
    send(8'h34, 1'b0);
    check("byp_pix1", out_pixel, 32'h34);
    @(posedge clk); #1;
    check("byp_drain", 32'(out_valid), 32'd0);

    // Invert, with a mid-frame mode write that must not take effect
    reg_wr(5'h00, 8'h01);
    send(8'h0F, 1'b1);
    check("inv_pix0", out_pixel, 32'hF0);
    reg_wr(5'h00, 8'h00);
    send(8'h20, 1'b0);
    check("inv_midframe", out_pixel, 32'hDF);
    reg_chk("inv_status", 5'h10, 8'hA1);

    // Threshold at the default 0x80
    reg_wr(5'h00, 8'h03);
    send(8'h7F, 1'b1);
    check("thr_below", out_pixel, 32'h00);
    check("thr_below_valid", 32'(out_valid), 32'd1);
    send(8'h80, 1'b0);
    check("thr_equal", out_pixel, 32'hFF);

    // Convolution, all-ones kernel on a constant frame
    reg_wr(5'h00, 8'h02);
    for (int i = 0; i < 9; i++) k[i] = 8'h01;
    set_kernel(k);
    frame(0, n_out, first_idx, vals);
    check("conv1_count", 32'(n_out), 32'd4);
    check("conv1_first_idx", 32'(first_idx), 32'd10);
    check("conv1_first", vals[0], 32'd90);
    check("conv1_last", vals[3], 32'd90);
    reg_chk("conv1_status", 5'h10, 8'hA6);

    // Corner/edge taps: k0=2, k2=-1, k6=5, k8=3 on a ramp frame
    k = '{8'd2, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd3};
    set_kernel(k);
    reg_chk("k2_readback", 5'h06, 8'hFF);
    frame(1, n_out, first_idx, vals);
    check("conv2_count", 32'(n_out), 32'd4);
    check("conv2_r2c2", vals[0], 32'd77);
    check("conv2_r2c3", vals[1], 32'd86);
    check("conv2_r3c2", vals[2], 32'd113);
    check("conv2_r3c3", vals[3], 32'd122);

    // Negative centre tap gives a sign-extended result
    k = '{8'd0, 8'd0, 8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0};
    set_kernel(k);
    frame(2, n_out, first_idx, vals);
    check("conv3_first_idx", 32'(first_idx), 32'd10);
    check("conv3_neg", vals[0], 32'hFFFFFF38);

    // Back-pressure: output held, input stalled, nothing lost
    reg_wr(5'h00, 8'h00);
    out_ready = 1'b0;
    send(8'h55, 1'b1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_pix", out_pixel, 32'h55);
    in_valid = 1'b1; in_data = 8'h66; in_sof = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", out_pixel, 32'h55);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_pix", out_pixel, 32'h66);

    // Stalled start-of-frame sets the sticky error; a write to status clears it
    out_ready = 1'b0;
    in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    check("sof_stall_hold", out_pixel, 32'h66);
    reg_chk("err_set", 5'h10, 8'hA8);
    reg_chk("frame_count", 5'h11, 8'h07);
    reg_wr(5'h10, 8'h00);
    reg_chk("err_clear", 5'h10, 8'hA0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("sof_stall_drain", 32'(out_valid), 32'd0);

    // Reset mid-frame aborts the frame; non-sof data then flows in bypass
    reg_wr(5'h00, 8'h01);
    send(8'h01, 1'b1);
    check("pre_rst_pix", out_pixel, 32'hFE);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pix", out_pixel, 32'd0);
    reg_chk("mid_rst_mode", 5'h00, 8'h00);
    reg_chk("mid_rst_fc", 5'h11, 8'h00);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    send(8'h12, 1'b0);
    check("post_rst_byp", out_pixel, 32'h12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_stream_proc.md
PIXEL_STREAM_PROC -- requirements
Module: pixel_stream_proc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, unsigned input pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, 32, pixels per line (line-buffer depth), >=3.
REQ-003 SHALL have parameter OUT_WIDTH, 32, signed result width, >= DATA_WIDTH+12.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_WIDTH, in_sof input 1 (first pixel of frame, qualified by in_valid).
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_pixel output OUT_WIDTH.
REQ-008 SHALL have ports reg_write_en input 1, reg_addr input 5, reg_wdata input 8, reg_rdata output 8 (combinational read).

Function
REQ-009 Registers SHALL be: 0x00 mode[1:0] R/W; 0x01 threshold R/W; 0x04-0x0C kernel k0..k8, signed 8-bit, R/W; 0x10 status R; 0x11 frame_count[7:0] R; others read 0x00, writes ignored.
REQ-010 Status SHALL read {4'hA, err_sticky, primed, active_mode[1:0]}; any write to 0x10 SHALL clear err_sticky.
REQ-011 A pixel SHALL be accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-012 Output SHALL be a single registered stage: out_valid/out_pixel held stable while out_valid && !out_ready; out_valid cleared on out_ready when nothing new is loaded.
REQ-013 active_mode SHALL load from mode register only when a pixel with in_sof=1 is accepted; mode writes mid-frame SHALL not affect the current frame.
REQ-014 On accepted in_sof pixel: column=0, row=0, primed=0, frame_count increments (wraps 255->0), line buffers' contents considered invalid.
REQ-015 Column counter SHALL increment per accepted pixel and wrap IMG_WIDTH-1 -> 0, incrementing row; row SHALL saturate at 2.
REQ-016 Mode 00 bypass: out_pixel = zero-extended in_data, one cycle after acceptance.
REQ-017 Mode 01 invert: out_pixel = zero-extended (2^DATA_WIDTH-1 - in_data), latency 1.
REQ-018 Mode 11 threshold: out_pixel = 2^DATA_WIDTH-1 if in_data >= threshold else 0, latency 1.
REQ-019 Mode 10 convolution: two line buffers of IMG_WIDTH entries plus 3x3 window shift only on accepted pixels.
REQ-020 Conv window: k0 multiplies pixel (row-2,col-2), k8 multiplies current pixel, row-major between.
REQ-021 Conv result SHALL be signed sum of nine (unsigned pixel x signed kernel) products, sign-extended to OUT_WIDTH, no saturation.
REQ-022 Conv output SHALL be produced, latency 1, only for pixels with row==2 (primed) and column>=2; other accepted pixels produce no output.
REQ-023 primed SHALL be 1 once row reaches 2.
REQ-024 err_sticky SHALL set when in_valid=1 and in_ready=0 while in_sof=1 (frame start stalled).
REQ-025 Kernel/threshold writes SHALL take effect on the next accepted pixel.

Reset
REQ-026 On rstn low: out_valid=0, out_pixel=0, mode=0, active_mode=0, threshold=0x80, kernel identity (k4=1, others 0), counters/frame_count/primed/err_sticky=0.
REQ-027 Reset mid-frame SHALL abort the frame; next output requires a new in_sof pixel or bypass data.

Verification
REQ-028 Bypass, out_ready=1, pixels 0x12,0x34 -> out_pixel 0x12,0x34 each one cycle after acceptance.
REQ-029 Mode 01 written, sof pixel 0x0F -> 0xF0; mode written 00 mid-frame -> remaining frame still inverted.
REQ-030 Threshold 0x80, pixels 0x7F,0x80 -> 0x00,0xFF.
REQ-031 IMG_WIDTH=4, all k=1, frame of constant 10 -> first output on pixel (2,2) = 90; 4 outputs total for a 4x4 frame.
REQ-032 k4=-1 others 0, pixel 200 at window centre -> out_pixel 0xFFFFFF38.
REQ-033 out_ready=0 for 5 cycles -> in_ready=0, out_pixel stable, no data lost; sof stalled -> status bit3=1, cleared by write to 0x10.
